// File: rtl/store_write_buffer_if.sv
// CPU-side and memory-side signals of the posted-store write buffer.
// The buffer takes the slave view; the CPU/memory environment takes the master view.
interface store_write_buffer_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   logic [AW-1:0]              cpu_addr;
   logic [DW-1:0]              cpu_wdata;
   logic                       cpu_memwrite;
   logic                       cpu_memread;
   logic [DW-1:0]              cpu_rdata;
   logic                       stall;
   logic [AW-1:0]              mem_address;
   logic                       mem_memwrite;
   logic                       mem_memread;
   logic [DW-1:0]              mem_din;
   logic [DW-1:0]              mem_dout;
   logic [$clog2(DEPTH+1)-1:0] buf_count;
   logic                       buf_empty;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, mem_dout,
      output cpu_rdata, stall, mem_address, mem_memwrite, mem_memread, mem_din,
             buf_count, buf_empty
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, mem_dout,
      input  cpu_rdata, stall, mem_address, mem_memwrite, mem_memread, mem_din,
             buf_count, buf_empty
   );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-store FIFO: stores are queued and retired over the shared memory port
// whenever a load miss does not own it; loads forward from the youngest match.
module store_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                clk,
   input  logic                reset,
   store_write_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_match;
   logic [DW-1:0] w_fwd;
   logic          w_hit;
   logic          w_miss;
   logic          w_drain;
   logic          w_full;
   logic          w_stall;
   logic          w_push;

   // Walk oldest to youngest so the last match found is the youngest store.
   always_comb begin
      w_match = 1'b0;
      w_fwd   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < r_count) && (r_addr[r_head + PW'(k)] == bus.cpu_addr)) begin
            w_match = 1'b1;
            w_fwd   = r_data[r_head + PW'(k)];
         end
      end
   end

   assign w_hit   = bus.cpu_memread & w_match;
   assign w_miss  = bus.cpu_memread & ~w_match;
   assign w_drain = ~w_miss & (r_count != '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_stall = bus.cpu_memwrite & w_full & ~w_drain;
   assign w_push  = bus.cpu_memwrite & ~w_stall;

   // A load miss owns the port; otherwise the oldest entry drains.
   always_comb begin
      bus.mem_memread  = 1'b0;
      bus.mem_memwrite = 1'b0;
      bus.mem_address  = bus.cpu_addr;
      bus.mem_din      = '0;
      if (w_miss) begin
         bus.mem_memread = ~reset;
      end else if (w_drain) begin
         bus.mem_memwrite = ~reset;
         bus.mem_address  = r_addr[r_head];
         bus.mem_din      = r_data[r_head];
      end
   end

   assign bus.cpu_rdata = w_hit ? w_fwd : bus.mem_dout;
   assign bus.stall     = w_stall;
   assign bus.buf_count = r_count;
   assign bus.buf_empty = (r_count == '0);

   // Entry contents need no reset: occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= bus.cpu_addr;
         r_data[r_tail] <= bus.cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)  r_tail <= r_tail + PW'(1);
         if (w_drain) r_head <= r_head + PW'(1);
         if (w_push && !w_drain)      r_count <= r_count + CW'(1);
         else if (!w_push && w_drain) r_count <= r_count - CW'(1);
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed and random stimulus for store_write_buffer, checked each cycle
// against a queue-based model of the buffer plus a reference memory image.
module tb_store_write_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

   store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory attached to the DUT: 256 words, unwritten words read a fixed pattern.
   bit [31:0] mem [256];
   bit        wv  [256];
   int        bad_wr = 0;

   function automatic logic [31:0] init_val(input logic [7:0] a);
      return (a == 8'd7) ? 32'h0000_00AA : {16'hC0DE, 8'h00, a};
   endfunction

   always @(posedge clk) begin
      if (bus.mem_memwrite === 1'b1) begin
         mem[bus.mem_address[7:0]] <= bus.mem_din;
         wv[bus.mem_address[7:0]]  <= 1'b1;
         if (bus.mem_address >= 32'h40 && bus.mem_address <= 32'h42) bad_wr = bad_wr + 1;
      end
   end

   assign bus.mem_dout = wv[bus.mem_address[7:0]] ? mem[bus.mem_address[7:0]]
                                                  : init_val(bus.mem_address[7:0]);

   // Reference model state
   ent_t        q[$];
   logic [31:0] rmem [256];
   logic        e_drain, e_push;
   logic [31:0] e_a, e_d;
   int          nvec = 0;
   int          nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's request, then check every output against the model.
   task automatic apply(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
      logic        hit, miss, stl;
      logic [31:0] fw, ea, ed, er;
      bus.cpu_memwrite = we;
      bus.cpu_memread  = re;
      bus.cpu_addr     = a;
      bus.cpu_wdata    = d;
      #3;
      hit = 1'b0;
      fw  = '0;
      if (re) foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; fw = q[i].d; end
      miss    = re && !hit;
      e_drain = !miss && (q.size() > 0);
      stl     = we && (q.size() == DEPTH) && !e_drain;
      e_push  = we && !stl;
      e_a     = a;
      e_d     = d;
      ea      = (!miss && e_drain) ? q[0].a : a;
      ed      = (!miss && e_drain) ? q[0].d : 32'h0;
      er      = hit ? fw : rmem[ea[7:0]];
      chk("stall",     {63'h0, bus.stall},        {63'h0, stl});
      chk("memread",   {63'h0, bus.mem_memread},  {63'h0, miss});
      chk("memwrite",  {63'h0, bus.mem_memwrite}, {63'h0, e_drain});
      chk("mem_addr",  {32'h0, bus.mem_address},  {32'h0, ea});
      chk("mem_din",   {32'h0, bus.mem_din},      {32'h0, ed});
      chk("cpu_rdata", {32'h0, bus.cpu_rdata},    {32'h0, er});
      chk("buf_count", {61'h0, bus.buf_count},    64'(q.size()));
      chk("buf_empty", {63'h0, bus.buf_empty},    {63'h0, (q.size() == 0)});
   endtask

   task automatic tick();
      @(posedge clk);
      if (e_drain) begin
         rmem[q[0].a[7:0]] = q[0].d;
         void'(q.pop_front());
      end
      if (e_push) q.push_back('{a: e_a, d: e_d});
      #1;
   endtask

   task automatic drain_all();
      for (int k = 0; k < DEPTH + 2 && q.size() > 0; k++) begin
         apply(1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end
      apply(1'b0, 1'b0, 32'h0, 32'h0);
      chk("drained", {61'h0, bus.buf_count}, 64'h0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rmem[i] = init_val(8'(i));
      e_drain = 1'b0;
      e_push  = 1'b0;
      e_a     = '0;
      e_d     = '0;

      // Reset: outputs quiet even with a load request present
      bus.cpu_memwrite = 1'b0;
      bus.cpu_memread  = 1'b1;
      bus.cpu_addr     = 32'd7;
      bus.cpu_wdata    = '0;
      #3;
      chk("rst_memread",  {63'h0, bus.mem_memread},  64'h0);
      chk("rst_memwrite", {63'h0, bus.mem_memwrite}, 64'h0);
      chk("rst_stall",    {63'h0, bus.stall},        64'h0);
      chk("rst_empty",    {63'h0, bus.buf_empty},    64'h1);
      chk("rst_count",    {61'h0, bus.buf_count},    64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single store retires the next cycle
      apply(1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
      tick();
      apply(1'b0, 1'b0, 32'd5, 32'h0);
      chk("t1_memwrite", {63'h0, bus.mem_memwrite}, 64'h1);
      chk("t1_addr",     {32'h0, bus.mem_address},  64'h5);
      chk("t1_din",      {32'h0, bus.mem_din},      64'hDEADBEEF);
      tick();
      apply(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1_empty", {63'h0, bus.buf_empty}, 64'h1);
      tick();

      // Duplicate stores: load forwards the youngest
      apply(1'b1, 1'b0, 32'h10, 32'h1);
      tick();
      apply(1'b1, 1'b0, 32'h10, 32'h2);
      tick();
      apply(1'b0, 1'b1, 32'h10, 32'h0);
      chk("t2_fwd",     {32'h0, bus.cpu_rdata},   64'h2);
      chk("t2_memread", {63'h0, bus.mem_memread}, 64'h0);
      tick();
      drain_all();

      // Fill to DEPTH behind load misses to addr 7
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, 1'b1, 32'd7, 32'h0);
         chk("t3_rdata",    {32'h0, bus.cpu_rdata},    64'hAA);
         chk("t3_memwrite", {63'h0, bus.mem_memwrite}, 64'h0);
         tick();
         apply(1'b1, 1'b1, 32'h20 + 32'(i), $urandom);
         chk("t3_fill_memwrite", {63'h0, bus.mem_memwrite}, 64'h0);
         tick();
      end
      apply(1'b1, 1'b0, 32'h30, 32'h3030_3030);
      chk("t3_full_count", {61'h0, bus.buf_count},    64'h4);
      chk("t3_full_stall", {63'h0, bus.stall},        64'h0);
      chk("t3_full_drain", {63'h0, bus.mem_memwrite}, 64'h1);
      tick();
      apply(1'b0, 1'b1, 32'd7, 32'h0);
      chk("t3_count_kept", {61'h0, bus.buf_count}, 64'h4);
      tick();
      // Store concurrent with a hitting load while full
      apply(1'b1, 1'b1, 32'h22, 32'h2222_0000);
      chk("t4_stall", {63'h0, bus.stall},        64'h0);
      chk("t4_drain", {63'h0, bus.mem_memwrite}, 64'h1);
      tick();
      drain_all();

      // Asynchronous reset mid-cycle discards three pending stores
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b1, 32'h40 + 32'(i), $urandom);
         tick();
      end
      apply(1'b0, 1'b1, 32'h80, 32'h0);
      reset = 1'b1;
      #1;
      chk("t5_count",    {61'h0, bus.buf_count},    64'h0);
      chk("t5_memwrite", {63'h0, bus.mem_memwrite}, 64'h0);
      chk("t5_empty",    {63'h0, bus.buf_empty},    64'h1);
      bus.cpu_memread = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      q.delete();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end
      chk("t5_no_write", 64'(bad_wr), 64'h0);

      // Ten back-to-back stores wrap both pointers
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, 1'b0, 32'h50 + 32'(i), $urandom);
         tick();
      end
      drain_all();
      for (int i = 0; i < 10; i++)
         chk("t6_mem", {32'h0, (wv[8'h50 + i] ? mem[8'h50 + i] : init_val(8'(8'h50 + i)))},
             {32'h0, rmem[8'h50 + i]});

      // Random mix, including simultaneous load and store
      for (int n = 0; n < 300; n++) begin
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               32'($urandom_range(0, 15)), $urandom);
         tick();
      end
      drain_all();
      for (int i = 0; i < 256; i++)
         chk("final_mem", {32'h0, (wv[i] ? mem[i] : init_val(8'(i)))}, {32'h0, rmem[i]});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
